// File: rtl/icnbc_sweep_ctrl.sv
// icnbc_sweep_ctrl
// Runs the icnbc code generator once for each min_ld in [ld_lo, ld_hi] with a
// fixed codeword length. Each run is bounded by a cycle timeout. The codewords
// the generator emits are counted, and the count saturates at MAX_CODES. Each
// run's outcome is offered on a valid/ready result port before the next run
// is launched.
module icnbc_sweep_ctrl #(
  parameter int N         = 8,
  parameter int MAX_CODES = 256,
  parameter int CNT_W     = 9,
  parameter int TIMEOUT   = 65535,
  parameter int TO_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N-1:0]     n_cfg,
  input  logic [N-1:0]     ld_lo,
  input  logic [N-1:0]     ld_hi,
  output logic             busy,
  output logic             done,
  output logic             err_cfg,
  output logic             gen_start,
  output logic [N-1:0]     gen_n,
  output logic [N-1:0]     gen_min_ld,
  input  logic             gen_code_valid,
  input  logic             gen_done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N-1:0]     res_min_ld,
  output logic [CNT_W-1:0] res_count,
  output logic             res_timeout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_REPORT = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CODES);
  localparam logic [TO_W-1:0]  TO_LIM  = TO_W'(TIMEOUT);
  localparam logic [N-1:0]     LD_ZERO = {N{1'b0}};
  localparam logic [N-1:0]     LD_ONE  = {{(N-1){1'b0}}, 1'b1};

  // Saturating code counter step: one increment per emitted codeword,
  // clamped at the generator memory depth.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    logic [CNT_W-1:0] r;
    if (en && (v != CNT_MAX)) begin
      r = v + CNT_W'(1);
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Configuration is rejected when the length is zero, when min_ld starts at
  // zero, or when the range is empty.
  function automatic logic cfg_bad(input logic [N-1:0] n,
                                   input logic [N-1:0] lo,
                                   input logic [N-1:0] hi);
    return (n == LD_ZERO) || (lo == LD_ZERO) || (lo > hi);
  endfunction

  state_e           state_q,       state_d;
  logic             busy_q,        busy_d;
  logic             done_q,        done_d;
  logic             err_cfg_q,     err_cfg_d;
  logic             gen_start_q,   gen_start_d;
  logic [N-1:0]     gen_n_q,       gen_n_d;
  logic [N-1:0]     cur_ld_q,      cur_ld_d;
  logic [N-1:0]     ld_hi_q,       ld_hi_d;
  logic [CNT_W-1:0] cnt_q,         cnt_d;
  logic [TO_W-1:0]  to_q,          to_d;
  logic             res_valid_q,   res_valid_d;
  logic [N-1:0]     res_min_ld_q,  res_min_ld_d;
  logic [CNT_W-1:0] res_count_q,   res_count_d;
  logic             res_timeout_q, res_timeout_d;

  // Counter values a RUN cycle would produce. A codeword that arrives in the
  // same cycle as gen_done is included.
  logic [CNT_W-1:0] cnt_inc;
  logic [TO_W-1:0]  to_inc;

  // Next-state and next-output logic. Outputs are computed for the state
  // being entered so that each registered output matches its state.
  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    err_cfg_d     = 1'b0;
    gen_start_d   = 1'b0;
    gen_n_d       = gen_n_q;
    cur_ld_d      = cur_ld_q;
    ld_hi_d       = ld_hi_q;
    cnt_d         = cnt_q;
    to_d          = to_q;
    res_valid_d   = res_valid_q;
    res_min_ld_d  = res_min_ld_q;
    res_count_d   = res_count_q;
    res_timeout_d = res_timeout_q;
    cnt_inc       = sat_inc(cnt_q, gen_code_valid);
    to_inc        = to_q + TO_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_bad(n_cfg, ld_lo, ld_hi)) begin
            err_cfg_d = 1'b1;
          end else begin
            gen_n_d     = n_cfg;
            cur_ld_d    = ld_lo;
            ld_hi_d     = ld_hi;
            gen_start_d = 1'b1;
            busy_d      = 1'b1;
            state_d     = S_LAUNCH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_LAUNCH: begin
        // Anything the generator signals during the launch cycle is ignored.
        cnt_d   = {CNT_W{1'b0}};
        to_d    = {TO_W{1'b0}};
        state_d = S_RUN;
      end

      S_RUN: begin
        cnt_d = cnt_inc;
        to_d  = to_inc;
        if (gen_done) begin
          res_valid_d   = 1'b1;
          res_min_ld_d  = cur_ld_q;
          res_count_d   = cnt_inc;
          res_timeout_d = 1'b0;
          state_d       = S_REPORT;
        end else if (to_inc == TO_LIM) begin
          res_valid_d   = 1'b1;
          res_min_ld_d  = cur_ld_q;
          res_count_d   = cnt_inc;
          res_timeout_d = 1'b1;
          state_d       = S_REPORT;
        end else begin
          state_d = S_RUN;
        end
      end

      S_REPORT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          // Compare with ld_hi before incrementing, so that ld_hi at the
          // top of the range never wraps.
          if (cur_ld_q == ld_hi_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            cur_ld_d    = cur_ld_q + LD_ONE;
            gen_start_d = 1'b1;
            state_d     = S_LAUNCH;
          end
        end else begin
          state_d = S_REPORT;
        end
      end

      default: begin
        busy_d      = 1'b0;
        res_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and output registers. An asynchronous reset aborts any sweep
  // without emitting a result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_cfg_q     <= 1'b0;
      gen_start_q   <= 1'b0;
      gen_n_q       <= {N{1'b0}};
      cur_ld_q      <= {N{1'b0}};
      ld_hi_q       <= {N{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      to_q          <= {TO_W{1'b0}};
      res_valid_q   <= 1'b0;
      res_min_ld_q  <= {N{1'b0}};
      res_count_q   <= {CNT_W{1'b0}};
      res_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_cfg_q     <= err_cfg_d;
      gen_start_q   <= gen_start_d;
      gen_n_q       <= gen_n_d;
      cur_ld_q      <= cur_ld_d;
      ld_hi_q       <= ld_hi_d;
      cnt_q         <= cnt_d;
      to_q          <= to_d;
      res_valid_q   <= res_valid_d;
      res_min_ld_q  <= res_min_ld_d;
      res_count_q   <= res_count_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err_cfg     = err_cfg_q;
  assign gen_start   = gen_start_q;
  assign gen_n       = gen_n_q;
  assign gen_min_ld  = cur_ld_q;
  assign res_valid   = res_valid_q;
  assign res_min_ld  = res_min_ld_q;
  assign res_count   = res_count_q;
  assign res_timeout = res_timeout_q;

endmodule

// File: doc/icnbc_sweep_ctrl.md
Name: icnbc_sweep_ctrl

Overview:
Sequencer that drives the icnbc code generator across a range of minimum Levenshtein distances for one codeword length. It launches one generator run per min_ld value and counts the codewords the generator emits. Each run's result (min_ld, codebook size, timeout flag) is delivered on a valid/ready result port. The block sits between the host/config logic and the icnbc instance and owns the generator's start and config inputs.

Parameters:
N, 8, codeword width; also the width of n and min_ld fields.
MAX_CODES, 256, generator memory depth; upper bound on codewords per run.
CNT_W, 9, result count width; must satisfy 2^CNT_W > MAX_CODES.
TIMEOUT, 65535, maximum cycles spent in RUN before a run is aborted.
TO_W, 16, timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  sweep request; sampled only in IDLE.
n_cfg  in  N  codeword length for the sweep.
ld_lo  in  N  first min_ld value.
ld_hi  in  N  last min_ld value (inclusive).
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when the sweep completes.
err_cfg  out  1  one-cycle pulse when start is rejected.
gen_start  out  1  one-cycle launch pulse to the generator.
gen_n  out  N  n to the generator; held constant for the whole sweep.
gen_min_ld  out  N  min_ld to the generator; held constant for the whole run.
gen_code_valid  in  1  generator emits one codeword this cycle.
gen_done  in  1  generator finished the current run.
res_valid  out  1  result available.
res_ready  in  1  consumer accepts the result.
res_min_ld  out  N  min_ld of the reported run.
res_count  out  CNT_W  codewords counted in the run.
res_timeout  out  1  the run was aborted by timeout.

Behaviour:
- Reset, asynchronous on rst_n=0: FSM goes to IDLE. All outputs and counters clear to 0, including gen_start, gen_n, gen_min_ld, res_*, done and err_cfg. A reset in any state aborts the sweep immediately; no result is emitted.
- States: IDLE, LAUNCH, RUN, REPORT. All outputs are registered.
- IDLE, start=1:
  - If n_cfg==0, ld_lo==0 or ld_lo>ld_hi: pulse err_cfg the next cycle and stay in IDLE.
  - Otherwise latch n_cfg, ld_lo and ld_hi, set cur_ld=ld_lo, and go to LAUNCH.
- LAUNCH, one cycle:
  - gen_start=1, with gen_n and gen_min_ld=cur_ld valid in the same cycle.
  - Clear the code counter and timeout counter, then go to RUN.
  - gen_start therefore rises exactly 1 cycle after the accepting start edge.
- RUN:
  - Each gen_code_valid increments the code counter, saturating at MAX_CODES.
  - The timeout counter increments every cycle.
  - If gen_done=1, go to REPORT with res_timeout=0. A gen_code_valid in the same cycle as gen_done is still counted.
  - Else if the timeout counter reaches TIMEOUT, go to REPORT with res_timeout=1.
- REPORT:
  - res_valid=1, with res_min_ld, res_count and res_timeout stable until the handshake (res_valid && res_ready).
  - On the handshake: if cur_ld==ld_hi, pulse done, clear res_valid and go to IDLE. Otherwise cur_ld+1 and go to LAUNCH.
  - The ld_hi comparison happens before the increment, so ld_hi=2^N-1 never wraps.
- res_valid rises 1 cycle after the gen_done cycle. Back-to-back: res_ready=1 yields the next gen_start 1 cycle after the handshake.
- Ignored inputs:
  - start while busy=1 is ignored.
  - gen_done and gen_code_valid outside RUN are ignored and not counted.
  - Config input changes after acceptance have no effect.
- done and err_cfg are never asserted together. busy=0 in the cycle done is high.

Test Plan:
- Basic sweep: n_cfg=8, ld_lo=2, ld_hi=4; generator model emits 5, 3, 2 codes then gen_done -> three results (2,5,0), (3,3,0), (4,2,0); 3 gen_start pulses; then done pulse, busy=0.
- Config errors: ld_lo=5, ld_hi=3 -> err_cfg one-cycle pulse, busy stays 0, no gen_start. Repeat with ld_lo=0 and n_cfg=0 -> same response.
- Backpressure and simultaneous events: hold res_ready=0 for 10 cycles -> res_* stable, no new gen_start. Raise gen_code_valid together with gen_done -> that code is counted.
- Timeout: TIMEOUT=100, generator never asserts gen_done -> result after 100 RUN cycles with res_timeout=1; the sweep continues to the next min_ld.
- Saturation and boundaries: 300 valid codes -> res_count=256. ld_lo=ld_hi=255 -> exactly one run, then done, with no wrap.
- Reset mid-RUN: assert rst_n=0 during RUN -> all outputs 0 asynchronously. After release, start works normally and gen_start appears 1 cycle after start.
